// File: rtl/em_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// em_access_arbiter_if
//   Requester-side bundle of the external byte-memory arbiter. Both requesters
//   (port 0 = CPU data side, port 1 = program loader) and the shared return
//   signals travel together in this interface.
//
//   Parameters:
//     ADDR_W          byte address width
//
//   Signals:
//     req0/req1       request, held high until the matching ack
//     we0/we1         1 = write, 0 = read
//     size0/size1     1 = byte, 2 = half, 3 = word, 0 = no-op
//     addr0/addr1     base byte address
//     wdata0/wdata1   little-endian write data (byte 0 -> lane 0)
//     ack0/ack1       one-cycle completion pulses
//     rdata           data of the last completed read, zero-extended by size
//     err             one-cycle out-of-range pulse, coincident with ack
//
//   Modports:
//     master          requester view (drives requests, receives completion)
//     slave           arbiter view
// ----------------------------------------------------------------------------
interface em_access_arbiter_if #(
   parameter int ADDR_W = 10
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [1:0]        size0;
   logic [1:0]        size1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [31:0]       wdata0;
   logic [31:0]       wdata1;
   logic              ack0;
   logic              ack1;
   logic [31:0]       rdata;
   logic              err;

   modport master (
      output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, rdata, err
   );

   modport slave (
      input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
      output ack0, ack1, rdata, err
   );
endinterface

// File: rtl/em_access_arbiter.sv
// ----------------------------------------------------------------------------
// em_access_arbiter
//   Shares the external byte memory between the CPU data side (port 0) and the
//   program loader (port 1). Each transaction runs IDLE -> ISSUE -> DONE:
//   the grant and all memory-side outputs are registered in IDLE, the memory
//   sees the access for exactly one cycle in ISSUE (writes commit and reads
//   are captured at the ISSUE -> DONE edge), and DONE pulses the ack.
//   Ties are resolved round-robin; after reset port 0 wins the first tie.
//
//   Optional feature (macro EM_ARBITER_BOUNDS_CHECK_EN):
//     when defined, an access whose used lanes reach MEM_SIZE or wrap past
//     the top of the address space is suppressed (em_control stays 0),
//     rdata is cleared and err pulses with the ack. When undefined, err is
//     tied low and accesses are issued unchanged.
//
//   Parameters:
//     MEM_SIZE        number of valid bytes (address valid iff < MEM_SIZE)
//     ADDR_W          byte address width; lane addresses wrap mod 2^ADDR_W
//
//   Ports:
//     clock           rising-edge clock
//     reset           asynchronous active-low reset
//     bus             requester interface (slave modport)
//     em_control      memory control: 0 none, 1 byte, 2 half, 3 word write
//     em_address      packed lane addresses {A3, A2, A1, A0}
//     em_dw0..em_dw3  write data lanes (unused lanes are 0)
//     em_read         combinational memory read data
// ----------------------------------------------------------------------------
module em_access_arbiter #(
   parameter int MEM_SIZE = 49,
   parameter int ADDR_W   = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   em_access_arbiter_if.slave    bus,
   output logic [2:0]            em_control,
   output logic [4*ADDR_W-1:0]   em_address,
   output logic [7:0]            em_dw0,
   output logic [7:0]            em_dw1,
   output logic [7:0]            em_dw2,
   output logic [7:0]            em_dw3,
   input  logic [31:0]           em_read
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t      state;
   logic        last_grant;
   logic        grant;
   logic        l_we;
   logic [1:0]  l_size;
   logic        ack0_q;
   logic        ack1_q;
   logic [31:0] rdata_q;

   // Selected requester, valid while IDLE
   logic              pick;
   logic              sel_we;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_oob;

   // Keeps the bytes a transfer of the given size uses; size 0 keeps nothing.
   function automatic logic [31:0] size_mask(input logic [31:0] d, input logic [1:0] sz);
      case (sz)
         2'd1:    return {24'd0, d[7:0]};
         2'd2:    return {16'd0, d[15:0]};
         2'd3:    return d;
         default: return 32'd0;
      endcase
   endfunction

   // Unused lanes repeat A0 so the memory never flags a lane that is not
   // part of the access (e.g. a byte at MEM_SIZE-1 still reads real data).
   function automatic logic [4*ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] sz);
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] a2;
      logic [ADDR_W-1:0] a3;
      a1 = (sz == 2'd2 || sz == 2'd3) ? a + ADDR_W'(1) : a;
      a2 = (sz == 2'd3) ? a + ADDR_W'(2) : a;
      a3 = (sz == 2'd3) ? a + ADDR_W'(3) : a;
      return {a3, a2, a1, a};
   endfunction

`ifdef EM_ARBITER_BOUNDS_CHECK_EN
   logic oob_q;
   logic err_q;

   // Used lanes are contiguous, so checking the last one (computed one bit
   // wider to expose wrap-around) covers the whole access.
   function automatic logic out_of_range(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
      logic [ADDR_W:0] last;
      last = {1'b0, a} + ((sz == 2'd3) ? (ADDR_W+1)'(3) :
                          (sz == 2'd2) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(0));
      return (sz != 2'd0) && (last[ADDR_W] || (int'(last) >= MEM_SIZE));
   endfunction

   assign sel_oob = out_of_range(sel_addr, sel_size);
   assign bus.err = err_q;
`else
   assign sel_oob = 1'b0;
   assign bus.err = 1'b0;
`endif

   // Round-robin: on a tie the port not granted last time wins.
   always_comb begin
      pick = 1'b0;
      if (bus.req0 && bus.req1) pick = ~last_grant;
      else                      pick = bus.req1;
      sel_we    = pick ? bus.we1    : bus.we0;
      sel_size  = pick ? bus.size1  : bus.size0;
      sel_addr  = pick ? bus.addr1  : bus.addr0;
      sel_wdata = pick ? bus.wdata1 : bus.wdata0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         l_we       <= 1'b0;
         l_size     <= 2'd0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata_q    <= 32'd0;
         em_control <= 3'd0;
         em_address <= '0;
         em_dw0     <= 8'd0;
         em_dw1     <= 8'd0;
         em_dw2     <= 8'd0;
         em_dw3     <= 8'd0;
`ifdef EM_ARBITER_BOUNDS_CHECK_EN
         oob_q      <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
`ifdef EM_ARBITER_BOUNDS_CHECK_EN
         err_q  <= 1'b0;
`endif
         case (state)
            // Grant and present the access for the ISSUE cycle
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  grant      <= pick;
                  last_grant <= pick;
                  l_we       <= sel_we;
                  l_size     <= sel_size;
`ifdef EM_ARBITER_BOUNDS_CHECK_EN
                  oob_q      <= sel_oob;
`endif
                  em_address <= lane_addr(sel_addr, sel_size);
                  if (sel_we && !sel_oob) begin
                     {em_dw3, em_dw2, em_dw1, em_dw0} <= size_mask(sel_wdata, sel_size);
                     em_control <= {1'b0, sel_size};
                  end else begin
                     {em_dw3, em_dw2, em_dw1, em_dw0} <= 32'd0;
                     em_control <= 3'd0;
                  end
                  state <= ISSUE;
               end
            end
            // Memory commits / read data captured at this edge
            ISSUE: begin
               em_control <= 3'd0;
               em_address <= '0;
               {em_dw3, em_dw2, em_dw1, em_dw0} <= 32'd0;
`ifdef EM_ARBITER_BOUNDS_CHECK_EN
               if (oob_q)
                  rdata_q <= 32'd0;
               else if (!l_we && l_size != 2'd0)
                  rdata_q <= size_mask(em_read, l_size);
               err_q <= oob_q;
`else
               if (!l_we && l_size != 2'd0)
                  rdata_q <= size_mask(em_read, l_size);
`endif
               ack0_q <= ~grant;
               ack1_q <= grant;
               state  <= DONE;
            end
            // Ack is visible this cycle
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_em_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_em_access_arbiter
//   Bench for em_access_arbiter with a behavioural 49-byte memory. Table rows
//   give single transactions with their expected ISSUE-cycle memory outputs;
//   ack port / rdata / err expectations go into a scoreboard queue that is
//   drained whenever an ack appears. Hand-written sequences cover the
//   round-robin tie, the range boundary and reset during ISSUE.
// ----------------------------------------------------------------------------
module tb_em_access_arbiter;
   localparam int MEM_SIZE = 49;
   localparam int ADDR_W   = 10;

   logic        clock;
   logic        reset;
   logic [2:0]  em_control;
   logic [39:0] em_address;
   logic [7:0]  em_dw0, em_dw1, em_dw2, em_dw3;
   logic [31:0] em_read;
   logic [7:0]  mem [0:1023];
   logic        mem_clr;

   int checks;
   int failures;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  exp_ctrl;
      logic [39:0] exp_addr;
      logic [31:0] exp_dw;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[10];

   em_access_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   em_access_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .em_control (em_control),
      .em_address (em_address),
      .em_dw0     (em_dw0),
      .em_dw1     (em_dw1),
      .em_dw2     (em_dw2),
      .em_dw3     (em_dw3),
      .em_read    (em_read)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural memory: writes commit at the clock edge, reads are combinational
   always @(posedge clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (em_control != 3'd0) begin
         if (int'(em_address[9:0]) < MEM_SIZE) mem[em_address[9:0]] <= em_dw0;
         if (em_control >= 3'd2 && int'(em_address[19:10]) < MEM_SIZE) mem[em_address[19:10]] <= em_dw1;
         if (em_control == 3'd3 && int'(em_address[29:20]) < MEM_SIZE) mem[em_address[29:20]] <= em_dw2;
         if (em_control == 3'd3 && int'(em_address[39:30]) < MEM_SIZE) mem[em_address[39:30]] <= em_dw3;
      end
   end

   assign em_read[7:0]   = (int'(em_address[9:0])   < MEM_SIZE) ? mem[em_address[9:0]]   : 8'd0;
   assign em_read[15:8]  = (int'(em_address[19:10]) < MEM_SIZE) ? mem[em_address[19:10]] : 8'd0;
   assign em_read[23:16] = (int'(em_address[29:20]) < MEM_SIZE) ? mem[em_address[29:20]] : 8'd0;
   assign em_read[31:24] = (int'(em_address[39:30]) < MEM_SIZE) ? mem[em_address[39:30]] : 8'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] pk(input int a3, input int a2, input int a1, input int a0);
      return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
   endfunction

   // Scoreboard: every ack is matched against the oldest expectation
   always @(negedge clock) begin
      if (bus.ack0 || bus.ack1) begin
         chk("ack_exclusive", {63'd0, bus.ack0 & bus.ack1}, 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_ack", {62'd0, bus.ack1, bus.ack0}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_port", {63'd0, bus.ack1}, {63'd0, e.port});
            chk("rdata", {32'd0, bus.rdata}, {32'd0, e.rdata});
            chk("err", {63'd0, bus.err}, {63'd0, e.err});
         end
      end
   end

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.size0 = 2'd0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.size1 = 2'd0; bus.addr1 = '0; bus.wdata1 = '0;
   endtask

   task automatic drive(input logic p, input logic we, input logic [1:0] sz,
                        input logic [9:0] a, input logic [31:0] wd);
      if (!p) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = wd;
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = wd;
      end
   endtask

   // Waits up to 8 cycles for an ack; lat = cycles waited, -1 on timeout
   task automatic wait_ack(output int lat);
      lat = -1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         if (bus.ack0 || bus.ack1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ctrl"}, {61'd0, em_control}, 64'd0);
      chk({tag, "_addr"}, {24'd0, em_address}, 64'd0);
      chk({tag, "_dw"}, {32'd0, em_dw3, em_dw2, em_dw1, em_dw0}, 64'd0);
      chk({tag, "_acks"}, {62'd0, bus.ack1, bus.ack0}, 64'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      sb.push_back('{v.port, v.exp_rdata, 1'b0});
      @(negedge clock);
      drive(v.port, v.we, v.size, v.addr, v.wdata);
      @(negedge clock);
      chk("issue_ctrl", {61'd0, em_control}, {61'd0, v.exp_ctrl});
      chk("issue_addr", {24'd0, em_address}, {24'd0, v.exp_addr});
      chk("issue_dw", {32'd0, em_dw3, em_dw2, em_dw1, em_dw0}, {32'd0, v.exp_dw});
      wait_ack(lat);
      chk("ack_latency", 64'(lat), 64'd1);
      chk("done_ctrl", {61'd0, em_control}, 64'd0);
      idle_inputs();
   endtask

   initial begin
      int lat;
      int n;
      int prev;
      logic [31:0] last_rd;
      logic [2:0]  bc_ctrl;
      logic        bc_err;
      logic [31:0] bc_rd;
      logic [7:0]  bc_m47;
      logic [7:0]  bc_m48;

      checks   = 0;
      failures = 0;
      mem_clr  = 1'b1;
      reset    = 1'b0;
      idle_inputs();

      // p, we, size, addr, wdata, ctrl, {A3,A2,A1,A0}, dw, rdata after
      vecs[0] = '{1'b0, 1'b1, 2'd3, 10'd40, 32'h0A0B0C0D, 3'd3, pk(43, 42, 41, 40), 32'h0A0B0C0D, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 2'd3, 10'd40, 32'h0,        3'd0, pk(43, 42, 41, 40), 32'h0,        32'h0A0B0C0D};
      vecs[2] = '{1'b1, 1'b1, 2'd1, 10'd48, 32'hAAAA557F, 3'd1, pk(48, 48, 48, 48), 32'h0000007F, 32'h0A0B0C0D};
      vecs[3] = '{1'b1, 1'b0, 2'd1, 10'd48, 32'h0,        3'd0, pk(48, 48, 48, 48), 32'h0,        32'h0000007F};
      vecs[4] = '{1'b0, 1'b1, 2'd2, 10'd20, 32'hFFFF1234, 3'd2, pk(20, 20, 21, 20), 32'h00001234, 32'h0000007F};
      vecs[5] = '{1'b0, 1'b0, 2'd3, 10'd20, 32'h0,        3'd0, pk(23, 22, 21, 20), 32'h0,        32'h00001234};
      vecs[6] = '{1'b1, 1'b0, 2'd2, 10'd41, 32'h0,        3'd0, pk(41, 41, 42, 41), 32'h0,        32'h00000B0C};
      vecs[7] = '{1'b0, 1'b0, 2'd1, 10'd42, 32'h0,        3'd0, pk(42, 42, 42, 42), 32'h0,        32'h0000000B};
      vecs[8] = '{1'b1, 1'b1, 2'd0, 10'd5,  32'hFFFFFFFF, 3'd0, pk(5, 5, 5, 5),     32'h0,        32'h0000000B};
      vecs[9] = '{1'b0, 1'b0, 2'd0, 10'd40, 32'h0,        3'd0, pk(40, 40, 40, 40), 32'h0,        32'h0000000B};

      // Reset state
      repeat (3) @(negedge clock);
      chk_idle_outputs("in_reset");
      chk("in_reset_rdata", {32'd0, bus.rdata}, 64'd0);
      chk("in_reset_err", {63'd0, bus.err}, 64'd0);
      mem_clr = 1'b0;
      reset   = 1'b1;
      @(negedge clock);
      chk_idle_outputs("after_reset");

      // Round-robin: both held through three transactions -> 0, 1, 0
      sb.push_back('{1'b0, 32'h0, 1'b0});
      sb.push_back('{1'b1, 32'h0, 1'b0});
      sb.push_back('{1'b0, 32'h0, 1'b0});
      drive(1'b0, 1'b0, 2'd3, 10'd0, 32'h0);
      drive(1'b1, 1'b0, 2'd3, 10'd4, 32'h0);
      n = 0;
      prev = 0;
      for (int c = 0; c < 30 && n < 3; c++) begin
         @(negedge clock);
         if (bus.ack0 || bus.ack1) begin
            if (n == 0) chk("rr_first_latency", 64'(c), 64'd1);
            else        chk("rr_spacing", 64'(c - prev), 64'd3);
            prev = c;
            n++;
            if (n == 3) idle_inputs();
         end
      end
      chk("rr_count", 64'(n), 64'd3);
      idle_inputs();

      // Table-driven single transactions
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      last_rd = vecs[9].exp_rdata;
      chk("byte22_untouched", {56'd0, mem[22]}, 64'd0);

      // Word write straddling the end of memory
`ifdef EM_ARBITER_BOUNDS_CHECK_EN
      bc_ctrl = 3'd0; bc_err = 1'b1; bc_rd = 32'h0;    bc_m47 = 8'h00; bc_m48 = 8'h7F;
`else
      bc_ctrl = 3'd3; bc_err = 1'b0; bc_rd = last_rd;  bc_m47 = 8'h44; bc_m48 = 8'h33;
`endif
      sb.push_back('{1'b0, bc_rd, bc_err});
      @(negedge clock);
      drive(1'b0, 1'b1, 2'd3, 10'd47, 32'h11223344);
      @(negedge clock);
      chk("bound_ctrl", {61'd0, em_control}, {61'd0, bc_ctrl});
      chk("bound_addr", {24'd0, em_address}, {24'd0, pk(50, 49, 48, 47)});
      wait_ack(lat);
      chk("bound_ack_latency", 64'(lat), 64'd1);
      idle_inputs();
      @(negedge clock);
      chk("bound_mem47", {56'd0, mem[47]}, {56'd0, bc_m47});
      chk("bound_mem48", {56'd0, mem[48]}, {56'd0, bc_m48});

      // Reset asserted during ISSUE of a write
      @(negedge clock);
      drive(1'b0, 1'b1, 2'd3, 10'd0, 32'hDEADBEEF);
      @(negedge clock);
      chk("pre_abort_ctrl", {61'd0, em_control}, 64'd3);
      #1 reset = 1'b0;
      #1 chk_idle_outputs("abort");
      chk("abort_rdata", {32'd0, bus.rdata}, 64'd0);
      idle_inputs();
      @(negedge clock);
      chk("abort_mem", {32'd0, mem[3], mem[2], mem[1], mem[0]}, 64'd0);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      chk("abort_no_ack", {62'd0, bus.ack1, bus.ack0}, 64'd0);

      // First tie after reset goes to port 0
      sb.push_back('{1'b0, 32'h0, 1'b0});
      drive(1'b0, 1'b0, 2'd0, 10'd0, 32'h0);
      drive(1'b1, 1'b0, 2'd0, 10'd0, 32'h0);
      wait_ack(lat);
      chk("tie_latency", 64'(lat), 64'd2);
      idle_inputs();
      repeat (4) @(negedge clock);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
